// File: rtl/seven_segment_scanner_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment patterns are built active-high here and inverted at the pins.
package seven_segment_scanner_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Places individual lit segments at their bit positions (1 = lit).
    function automatic logic [6:0] seg_lit(
        input logic a,
        input logic b,
        input logic c,
        input logic d,
        input logic e,
        input logic f,
        input logic g
    );
        logic [6:0] v;
        v        = '0;
        v[SEG_A] = a;
        v[SEG_B] = b;
        v[SEG_C] = c;
        v[SEG_D] = d;
        v[SEG_E] = e;
        v[SEG_F] = f;
        v[SEG_G] = g;
        return v;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern (a..g at bits 0..6).
module seven_segment_decoder
    import seven_segment_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    logic [6:0] lit;

    always_comb begin
        lit = '0;
        case (nibble_i)
            4'h0: lit = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            4'h1: lit = seg_lit(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            4'h2: lit = seg_lit(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            4'h3: lit = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            4'h4: lit = seg_lit(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            4'h5: lit = seg_lit(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            4'h6: lit = seg_lit(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            4'h7: lit = seg_lit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            4'h8: lit = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            4'h9: lit = seg_lit(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            4'hA: lit = seg_lit(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            4'hB: lit = seg_lit(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            4'hC: lit = seg_lit(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            4'hD: lit = seg_lit(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            4'hE: lit = seg_lit(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            4'hF: lit = seg_lit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            default: lit = '0;
        endcase
        seg_o = ~lit;
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode display driver: advances one digit per scan_clk rising edge,
// with an all-dark blanking gap between digits to suppress ghosting.
module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int DIGIT_COUNT           = 4,
    parameter int DIGIT_INDEX_BIT_WIDTH = 2,
    parameter int BLANK_CYCLES          = 16,
    parameter int BLANK_BIT_WIDTH       = 5
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             scan_clk,
    input  logic [4*DIGIT_COUNT-1:0]         digits,
    input  logic [DIGIT_COUNT-1:0]           dots,
    input  logic [DIGIT_COUNT-1:0]           digit_enable,
    output logic [6:0]                       seg,
    output logic                             dp,
    output logic [DIGIT_COUNT-1:0]           anode,
    output logic [DIGIT_INDEX_BIT_WIDTH-1:0] digit_index
);

    localparam int BLANK_RELOAD = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
    localparam logic [BLANK_BIT_WIDTH-1:0] BLANK_RELOAD_V = BLANK_BIT_WIDTH'(BLANK_RELOAD);
    localparam logic [DIGIT_INDEX_BIT_WIDTH-1:0] LAST_INDEX = DIGIT_INDEX_BIT_WIDTH'(DIGIT_COUNT - 1);

    logic                             sync1_q;
    logic                             sync2_q;
    logic                             sync3_q;
    logic                             rise;

    state_e                           state_q;
    logic [BLANK_BIT_WIDTH-1:0]       blank_cnt_q;
    logic [DIGIT_INDEX_BIT_WIDTH-1:0] index_q;
    logic [6:0]                       seg_q;
    logic                             dp_q;
    logic [DIGIT_COUNT-1:0]           anode_q;

    logic [DIGIT_INDEX_BIT_WIDTH-1:0] index_d;
    logic [DIGIT_INDEX_BIT_WIDTH-1:0] load_index;
    logic [3:0]                       nibbles [DIGIT_COUNT];
    logic [3:0]                       load_nibble;
    logic [6:0]                       load_pattern;
    logic [DIGIT_COUNT-1:0]           anode_sel;
    logic [6:0]                       seg_d;
    logic                             dp_d;
    logic [DIGIT_COUNT-1:0]           anode_d;

    assign rise    = sync2_q & ~sync3_q;
    assign index_d = (index_q == LAST_INDEX) ? '0 : index_q + 1'b1;

    // From BLANK the index has already advanced; a direct load from SHOW uses the next one.
    assign load_index = (state_q == ST_SHOW) ? index_d : index_q;

    generate
        for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_digit
            assign nibbles[gi]   = digits[4*gi +: 4];
            assign anode_sel[gi] = (load_index != DIGIT_INDEX_BIT_WIDTH'(gi));
        end
    endgenerate

    assign load_nibble = nibbles[load_index];

    seven_segment_decoder u_decoder (
        .nibble_i (load_nibble),
        .seg_o    (load_pattern)
    );

    always_comb begin
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        anode_d = '1;
        if (digit_enable[load_index]) begin
            seg_d   = load_pattern;
            dp_d    = ~dots[load_index];
            anode_d = anode_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            state_q     <= ST_BLANK;
            blank_cnt_q <= BLANK_RELOAD_V;
            index_q     <= '0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            anode_q     <= '1;
        end else begin
            sync1_q <= scan_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            case (state_q)
                ST_BLANK: begin
                    // Any rise seen here is intentionally dropped.
                    if (blank_cnt_q == '0) begin
                        seg_q   <= seg_d;
                        dp_q    <= dp_d;
                        anode_q <= anode_d;
                        state_q <= ST_SHOW;
                    end else begin
                        blank_cnt_q <= blank_cnt_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (rise) begin
                        index_q <= index_d;
                        if (BLANK_CYCLES == 0) begin
                            seg_q   <= seg_d;
                            dp_q    <= dp_d;
                            anode_q <= anode_d;
                        end else begin
                            seg_q       <= SEG_OFF;
                            dp_q        <= 1'b1;
                            anode_q     <= '1;
                            blank_cnt_q <= BLANK_RELOAD_V;
                            state_q     <= ST_BLANK;
                        end
                    end
                end
            endcase
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign anode       = anode_q;
    assign digit_index = index_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized scoreboard bench for seven_segment_scanner (BLANK_CYCLES=16 and a BLANK_CYCLES=0 instance).
module tb_seven_segment_scanner;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_clk = 1'b0;
    logic        scan_clk0 = 1'b0;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [3:0]  digit_enable;
    logic [6:0]  seg, seg0;
    logic        dp, dp0;
    logic [3:0]  anode, anode0;
    logic [1:0]  digit_index, digit_index0;

    seven_segment_scanner #(
        .DIGIT_COUNT(4), .DIGIT_INDEX_BIT_WIDTH(2), .BLANK_CYCLES(16), .BLANK_BIT_WIDTH(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .scan_clk(scan_clk), .digits(digits), .dots(dots),
        .digit_enable(digit_enable), .seg(seg), .dp(dp), .anode(anode), .digit_index(digit_index)
    );

    seven_segment_scanner #(
        .DIGIT_COUNT(4), .DIGIT_INDEX_BIT_WIDTH(2), .BLANK_CYCLES(0), .BLANK_BIT_WIDTH(1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .scan_clk(scan_clk0), .digits(digits), .dots(dots),
        .digit_enable(digit_enable), .seg(seg0), .dp(dp0), .anode(anode0), .digit_index(digit_index0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] idx;
    } disp_t;

    typedef struct {
        disp_t d;
        int    cyc;
    } exp_t;

    exp_t  exp_q[$];
    disp_t m_last;
    disp_t prev;
    int    m_idx;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic disp_t dark(input int i);
        return {7'h7F, 1'b1, 4'hF, 2'(i)};
    endfunction

    function automatic disp_t expect_show(input int i);
        disp_t      d;
        logic [3:0] nib;
        if (!digit_enable[i]) return dark(i);
        nib   = digits[4*i +: 4];
        d.seg = hex_tbl[nib];
        d.dp  = ~dots[i];
        d.an  = 4'hF & ~(4'b0001 << i);
        d.idx = 2'(i);
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic push(input disp_t d, input int c);
        if (d !== m_last) begin
            exp_q.push_back('{d, c});
            m_last = d;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic randomize_inputs();
        digits       = 16'($urandom);
        dots         = 4'($urandom_range(0, 15));
        digit_enable = 4'($urandom_range(0, 15));
    endtask

    // Monitor: every visible change of the display must match the next expected event.
    always @(negedge clk) begin
        disp_t cur;
        exp_t  e;
        if (mon_en) begin
            cur = {seg, dp, anode, digit_index};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_change at cycle %0d: got %h, previous %h", cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    check("display", 32'(cur), 32'(e.d));
                    check("timing", cyc, e.cyc);
                    $display("txn cycle %0d display %h", cyc, cur);
                end
                prev = cur;
            end
        end
    end

    initial begin
        #300000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int N;
        int nxt;
        int Q;
        int idx0;
        int lim;
        digits       = 16'h3210;
        dots         = 4'h0;
        digit_enable = 4'hF;
        m_last       = dark(0);
        prev         = dark(0);
        m_idx        = 0;

        wait_cyc(3);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_anode", anode, 4'hF);
        check("reset_index", digit_index, 2'd0);
        mon_en = 1'b1;

        wait_cyc(4);
        push(expect_show(0), 4 + 16);
        reset_n = 1'b1;

        nxt = 25;
        for (int t = 0; t < 38; t++) begin
            wait_cyc(nxt);
            N = cyc;
            if (t == 0) begin
                digits = 16'hF8A1;
                dots   = 4'b0100;
            end else if (t == 4) begin
                digit_enable = 4'b1101;
            end else if (t == 8) begin
                digit_enable = 4'hF;
            end else if (t > 8 && $urandom_range(0, 1) == 1) begin
                randomize_inputs();
            end
            if (t == 37) digit_enable = 4'hF;
            scan_clk = 1'b1;
            m_idx = (m_idx + 1) % DC;
            push(dark(m_idx), N + 3);
            wait_cyc(N + 2);
            scan_clk = 1'b0;
            if (t == 2 || (t >= 8 && $urandom_range(0, 1) == 1)) begin
                wait_cyc(N + 5);
                scan_clk = 1'b1;
                wait_cyc(N + 7);
                scan_clk = 1'b0;
            end
            wait_cyc(N + 18);
            push(expect_show(m_idx), N + 19);
            if (t == 3) begin
                wait_cyc(N + 21);
                digits[3:0] = 4'h8;
            end else if (t >= 8 && t < 37 && $urandom_range(0, 1) == 1) begin
                wait_cyc(N + 19 + $urandom_range(1, 10));
                randomize_inputs();
            end
            nxt = N + $urandom_range(32, 60);
        end

        lim = cyc + 100;
        while (exp_q.size() != 0 && cyc < lim) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset between clock edges while a digit is lit.
        @(negedge clk);
        check("pre_reset_display", {seg, dp, anode, digit_index}, expect_show(m_idx));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_seg", seg, 7'h7F);
        check("async_reset_dp", dp, 1'b1);
        check("async_reset_anode", anode, 4'hF);
        check("async_reset_index", digit_index, 2'd0);
        check("async_reset_anode0", anode0, 4'hF);

        digits       = 16'($urandom);
        dots         = 4'($urandom_range(0, 15));
        digit_enable = 4'hF;
        @(negedge clk);
        wait_cyc(cyc + 2);
        Q = cyc;
        reset_n = 1'b1;

        wait_cyc(Q + 1);
        check("bc0_first_digit", {seg0, dp0, anode0, digit_index0}, expect_show(0));
        wait_cyc(Q + 15);
        check("restart_blank", {seg, dp, anode, digit_index}, dark(0));
        wait_cyc(Q + 16);
        check("restart_digit0", {seg, dp, anode, digit_index}, expect_show(0));

        idx0 = 0;
        for (int k = 0; k < 5; k++) begin
            N = cyc;
            scan_clk0 = 1'b1;
            wait_cyc(N + 2);
            check("bc0_before_switch", {seg0, dp0, anode0, digit_index0}, expect_show(idx0));
            scan_clk0 = 1'b0;
            idx0 = (idx0 + 1) % DC;
            wait_cyc(N + 3);
            check("bc0_switch", {seg0, dp0, anode0, digit_index0}, expect_show(idx0));
            $display("txn bc0 cycle %0d digit %0d display %h", cyc, idx0, {seg0, dp0, anode0, digit_index0});
            wait_cyc(N + 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
